prog_loader: RTL and testbench

Program-image loader that sits between the host word stream and the `scheduler`. It accepts a task/instruction image one 16-bit word at a time over a valid/ready handshake and assembles it in a local frame buffer. It drives `prog_loading` so the scheduler copies the complete image, then releases the scheduler to start dispatching frames to the cores.

---
 rtl/prog_loader_pkg.sv | 13 +
 rtl/prog_loader_if.sv | 14 +
 rtl/prog_image_buf.sv | 36 +++
 rtl/prog_loader.sv | 128 ++++++++++++
 tb/tb_prog_loader.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program-image loader: word width and FSM state encodings.
package prog_loader_pkg;

    localparam int PROG_WORD_W = 16;

    typedef enum logic [1:0] {
        PROG_ST_IDLE  = 2'd0,
        PROG_ST_LOAD  = 2'd1,
        PROG_ST_FLUSH = 2'd2,
        PROG_ST_DONE  = 2'd3
    } prog_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Host word-stream handshake (valid/ready with last marker) into the program loader.
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int W = PROG_WORD_W
);
    logic         host_valid;
    logic [W-1:0] host_data;
    logic         host_last;
    logic         host_ready;

    modport master (output host_valid, host_data, host_last, input host_ready);
    modport slave  (input host_valid, host_data, host_last, output host_ready);
endinterface

// File: rtl/prog_image_buf.sv
// Program image register array: one write port, synchronous clear-all, async reset,
// and every word exposed in parallel so the scheduler can copy the whole image.
module prog_image_buf #(
    parameter int DEPTH = 1024,
    parameter int W     = 16,
    parameter int AW    = $clog2(DEPTH)
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clr,
    input  logic                      i_we,
    input  logic [AW-1:0]             i_addr,
    input  logic [W-1:0]              i_wdata,
    output logic [DEPTH-1:0][W-1:0]   o_rdata_all
);

    // One register per word so the flat read-all output needs no read mux.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [W-1:0] r_word;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_word <= '0;
                end else if (i_clr) begin
                    r_word <= '0;
                end else if (i_we && (i_addr == AW'(gi))) begin
                    r_word <= i_wdata;
                end
            end

            assign o_rdata_all[gi] = r_word;
        end
    endgenerate

endmodule

// File: rtl/prog_loader.sv
// Program-image loader: assembles host words into a frame buffer and holds prog_loading
// high until the scheduler has seen the full image. Optional PROG_LOADER_CHKSUM_EN adds a zero-sum check.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DATA_DEPTH = 1024,
    parameter int INSTR_SIZE = PROG_WORD_W,
    parameter int CNT_W      = $clog2(DATA_DEPTH) + 1
)(
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    prog_loader_if.slave                         host,
    output logic                                 prog_loading,
    output logic [DATA_DEPTH-1:0][INSTR_SIZE-1:0] data_frames_out,
    output logic [CNT_W-1:0]                     word_cnt,
    output logic                                 load_done,
    output logic                                 load_err
`ifdef PROG_LOADER_CHKSUM_EN
    ,
    output logic [INSTR_SIZE-1:0]                chksum
`endif
);

    localparam int AW = $clog2(DATA_DEPTH);

    prog_state_t      r_state;
    prog_state_t      w_state_next;
    logic [CNT_W-1:0] r_word_cnt;
    logic             r_load_err;

    logic w_start;
    logic w_accept;
    logic w_at_end;
    logic w_ovf;
    logic w_err_set;

    assign w_start  = (r_state == PROG_ST_IDLE) && start;
    assign w_accept = (r_state == PROG_ST_LOAD) && host.host_valid;
    assign w_at_end = (r_word_cnt == CNT_W'(DATA_DEPTH - 1));
    // Filling the last slot without a last marker means the image did not fit.
    assign w_ovf    = w_accept && w_at_end && !host.host_last;

`ifdef PROG_LOADER_CHKSUM_EN
    logic [INSTR_SIZE-1:0] r_chksum;
    logic [INSTR_SIZE-1:0] w_sum;

    assign w_sum     = r_chksum + host.host_data;
    assign w_err_set = w_ovf || (w_accept && host.host_last && (w_sum != '0));
    assign chksum    = r_chksum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chksum <= '0;
        end else if (w_start) begin
            r_chksum <= '0;
        end else if (w_accept) begin
            r_chksum <= w_sum;
        end
    end
`else
    assign w_err_set = w_ovf;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= PROG_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PROG_ST_IDLE: begin
                if (start) begin
                    w_state_next = PROG_ST_LOAD;
                end
            end
            PROG_ST_LOAD: begin
                if (w_accept && (host.host_last || w_at_end)) begin
                    w_state_next = PROG_ST_FLUSH;
                end
            end
            PROG_ST_FLUSH: w_state_next = PROG_ST_DONE;
            PROG_ST_DONE:  w_state_next = PROG_ST_IDLE;
            default:       w_state_next = PROG_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word_cnt <= '0;
            r_load_err <= 1'b0;
        end else if (w_start) begin
            r_word_cnt <= '0;
            r_load_err <= 1'b0;
        end else if (w_accept) begin
            r_word_cnt <= r_word_cnt + 1'b1;
            if (w_err_set) begin
                r_load_err <= 1'b1;
            end
        end
    end

    // FLUSH keeps prog_loading up one extra cycle so the final word is sampled downstream.
    assign host.host_ready = (r_state == PROG_ST_LOAD);
    assign prog_loading    = (r_state == PROG_ST_LOAD) || (r_state == PROG_ST_FLUSH);
    assign load_done       = (r_state == PROG_ST_DONE);
    assign word_cnt        = r_word_cnt;
    assign load_err        = r_load_err;

    prog_image_buf #(
        .DEPTH (DATA_DEPTH),
        .W     (INSTR_SIZE),
        .AW    (AW)
    ) u_buf (
        .clk         (clk),
        .rst         (reset),
        .i_clr       (w_start),
        .i_we        (w_accept),
        .i_addr      (r_word_cnt[AW-1:0]),
        .i_wdata     (host.host_data),
        .o_rdata_all (data_frames_out)
    );

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: timeline-based reference model compared every cycle,
// plus directed loads with hand-computed expectations.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int DEPTH = 1024;
    localparam int W     = PROG_WORD_W;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int AW    = $clog2(DEPTH);
`ifdef PROG_LOADER_CHKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;

    prog_loader_if #(.W(W)) hif();

    logic                    prog_loading;
    logic [DEPTH-1:0][W-1:0] data_frames_out;
    logic [CW-1:0]           word_cnt;
    logic                    load_done;
    logic                    load_err;
`ifdef PROG_LOADER_CHKSUM_EN
    logic [W-1:0]            chksum;
`endif

    prog_loader #(.DATA_DEPTH(DEPTH), .INSTR_SIZE(W), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .host            (hif.slave),
        .prog_loading    (prog_loading),
        .data_frames_out (data_frames_out),
        .word_cnt        (word_cnt),
        .load_done       (load_done),
        .load_err        (load_err)
`ifdef PROG_LOADER_CHKSUM_EN
        ,
        .chksum          (chksum)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: tracks the load as a timeline (edge of start, edge of final word)
    int                      cyc;
    int                      t_last;
    int                      m_e;
    bit                      m_active;
    int                      m_cnt;
    logic [W-1:0]            m_sum;
    bit                      m_err;
    logic [DEPTH-1:0][W-1:0] m_img;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc = 0; t_last = -10; m_active = 0; m_cnt = 0;
            m_sum = '0; m_err = 0; m_img = '0;
        end else begin
            m_e = cyc + 1;
            if (m_active && hif.host_valid) begin
                m_img[m_cnt[AW-1:0]] = hif.host_data;
                m_cnt++;
                m_sum = m_sum + hif.host_data;
                if (hif.host_last) begin
                    m_active = 0; t_last = m_e;
                    if (CHK && m_sum != '0) m_err = 1;
                end else if (m_cnt == DEPTH) begin
                    m_active = 0; t_last = m_e; m_err = 1;
                end
            end else if (!m_active && m_e >= t_last + 3 && start) begin
                m_active = 1; m_cnt = 0; m_sum = '0; m_err = 0; m_img = '0;
            end
            cyc = m_e;
        end
    end

    int n_wr = 0;
    always @(posedge clk) begin
        if (!reset && hif.host_valid && hif.host_ready) n_wr++;
    end

    bit track = 0;
    int n_gap = 0;

    task automatic chk_frames(input string name);
        int idx;
        n_checks++;
        if (data_frames_out !== m_img) begin
            idx = 0;
            for (int i = DEPTH - 1; i >= 0; i--)
                if (data_frames_out[i[AW-1:0]] !== m_img[i[AW-1:0]]) idx = i;
            n_errors++;
            $display("FAIL %s word %0d: got %h expected %h", name, idx,
                     data_frames_out[idx[AW-1:0]], m_img[idx[AW-1:0]]);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("host_ready", 32'(hif.host_ready), 32'(m_active));
            chk("prog_loading", 32'(prog_loading), 32'(m_active || (cyc == t_last)));
            chk("load_done", 32'(load_done), 32'(cyc == t_last + 1));
            chk("load_err", 32'(load_err), 32'(m_err));
            chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
`ifdef PROG_LOADER_CHKSUM_EN
            chk("chksum", 32'(chksum), 32'(m_sum));
`endif
            chk_frames("frames");
            if (track && !prog_loading) n_gap++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic last);
        logic acc;
        bit   ok;
        hif.host_valid = 1'b1;
        hif.host_data  = d;
        hif.host_last  = last;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            acc = hif.host_ready;
            tick();
            if (acc) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got no accept expected accept of %h", d);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int w0;

    initial begin
        hif.host_valid = 1'b0;
        hif.host_data  = '0;
        hif.host_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ready", 32'(hif.host_ready), 32'd0);
        chk("rst_loading", 32'(prog_loading), 32'd0);
        chk("rst_cnt", 32'(word_cnt), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_frames", 32'(data_frames_out == '0), 32'd1);
        tick();

        // Four-word image
        do_start();
        chk("start_ready", 32'(hif.host_ready), 32'd1);
        chk("start_loading", 32'(prog_loading), 32'd1);
        send_word(16'h0103, 1'b0);
        send_word(16'h000F, 1'b0);
        send_word(16'h000F, 1'b0);
        send_word(16'h0001, 1'b1);
        hif.host_valid = 1'b0;
        hif.host_last  = 1'b0;
        chk("t1_flush_loading", 32'(prog_loading), 32'd1);
        chk("t1_flush_done", 32'(load_done), 32'd0);
        chk("t1_buf0", 32'(data_frames_out[0]), 32'h0103);
        chk("t1_buf1", 32'(data_frames_out[1]), 32'h000F);
        chk("t1_buf2", 32'(data_frames_out[2]), 32'h000F);
        chk("t1_buf3", 32'(data_frames_out[3]), 32'h0001);
        chk("t1_buf_rest", 32'(data_frames_out[DEPTH-1:4] == '0), 32'd1);
        tick();
        chk("t1_done", 32'(load_done), 32'd1);
        chk("t1_loading_fell", 32'(prog_loading), 32'd0);
        tick();
        chk("t1_done_pulse", 32'(load_done), 32'd0);
        chk("t1_cnt", 32'(word_cnt), 32'd4);
        chk("t1_err", 32'(load_err), 32'(CHK));

        // Host stalls every other cycle over 8 words
        w0 = n_wr;
        do_start();
        track = 1;
        for (int i = 0; i < 8; i++) begin
            send_word(16'(16'h0200 + i * 3), 1'(i == 7));
            hif.host_valid = 1'b0;
            hif.host_last  = 1'b0;
            if (i != 7) tick();
        end
        track = 0;
        tick();
        tick();
        chk("t2_writes", 32'(n_wr - w0), 32'd8);
        chk("t2_cnt", 32'(word_cnt), 32'd8);
        chk("t2_gaps", 32'(n_gap), 32'd0);
        chk("t2_buf7", 32'(data_frames_out[7]), 32'h0215);

        // Overflow: DEPTH words, no last marker, extra word offered afterwards
        w0 = n_wr;
        do_start();
        hif.host_valid = 1'b1;
        hif.host_last  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hif.host_data = 16'(i + 1);
            tick();
        end
        hif.host_data = 16'hFFFF;
        chk("t3_flush_loading", 32'(prog_loading), 32'd1);
        chk("t3_flush_ready", 32'(hif.host_ready), 32'd0);
        tick();
        tick();
        tick();
        hif.host_valid = 1'b0;
        chk("t3_writes", 32'(n_wr - w0), 32'(DEPTH));
        chk("t3_cnt", 32'(word_cnt), 32'(DEPTH));
        chk("t3_err", 32'(load_err), 32'd1);
        chk("t3_ready", 32'(hif.host_ready), 32'd0);
        chk("t3_buf_last", 32'(data_frames_out[DEPTH-1]), 32'h0400);

        // start ignored during LOAD, then reset mid-load
        do_start();
        send_word(16'h00A1, 1'b0);
        send_word(16'h00A2, 1'b0);
        hif.host_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_word(16'h00A3, 1'b0);
        send_word(16'h00A4, 1'b0);
        send_word(16'h00A5, 1'b0);
        hif.host_valid = 1'b0;
        chk("t4_cnt", 32'(word_cnt), 32'd5);
        chk("t4_buf0", 32'(data_frames_out[0]), 32'h00A1);
        #3;
        reset = 1'b1;
        #1;
        chk("t4_rst_loading", 32'(prog_loading), 32'd0);
        chk("t4_rst_ready", 32'(hif.host_ready), 32'd0);
        chk("t4_rst_cnt", 32'(word_cnt), 32'd0);
        chk("t4_rst_frames", 32'(data_frames_out == '0), 32'd1);
        #2;
        reset = 1'b0;
        tick();
        do_start();
        send_word(16'hAAAA, 1'b0);
        send_word(16'h5556, 1'b1);
        hif.host_valid = 1'b0;
        hif.host_last  = 1'b0;
        tick();
        tick();
        chk("t4_reload_buf0", 32'(data_frames_out[0]), 32'hAAAA);
        chk("t4_reload_buf1", 32'(data_frames_out[1]), 32'h5556);
        chk("t4_reload_cnt", 32'(word_cnt), 32'd2);
        chk("t4_reload_err", 32'(load_err), 32'd0);

`ifdef PROG_LOADER_CHKSUM_EN
        do_start();
        send_word(16'h1234, 1'b0);
        send_word(16'hEDCC, 1'b1);
        hif.host_valid = 1'b0;
        hif.host_last  = 1'b0;
        tick();
        tick();
        chk("t5_good_err", 32'(load_err), 32'd0);
        chk("t5_good_sum", 32'(chksum), 32'h0000);
        do_start();
        send_word(16'h1234, 1'b0);
        send_word(16'hEDCD, 1'b1);
        hif.host_valid = 1'b0;
        hif.host_last  = 1'b0;
        tick();
        tick();
        chk("t5_bad_err", 32'(load_err), 32'd1);
        chk("t5_bad_sum", 32'(chksum), 32'h0001);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timed out");
    end

endmodule
